// File: rtl/echo_heard_serializer.sv
// Purpose : buffer 32-bit heard words in a DEPTH-entry FIFO and emit them LSB-first as bytes.
// Latency : a word accepted in cycle N is popped in N+1 (if idle) and byte 0 appears in N+2.
// Backpr. : heard__RDY drops when the FIFO is full; byte__RDY low freezes the serializer.
//
// Ports:
//   CLK, nRST             clock, asynchronous active-low reset
//   heard__ENA/heard_v    upstream word delivery (only while heard__RDY)
//   heard__RDY            FIFO has room (registered occupancy only)
//   byte__ENA/byte_v      byte transferred this cycle / current byte
//   byte_last             current byte is byte 3 of its word
//   byte__RDY             downstream can accept a byte
//   word_count            words fully emitted, wraps at 2^16
module echo_heard_serializer #(
   parameter int DEPTH = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        heard__ENA,
   input  logic [31:0] heard_v,
   output logic        heard__RDY,
   output logic        byte__ENA,
   output logic [7:0]  byte_v,
   output logic        byte_last,
   input  logic        byte__RDY,
   output logic [15:0] word_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state_q, state_d;
   logic [31:0]   sr_q, sr_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   word_count_q, word_count_d;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   occ_q, occ_d;
   logic [31:0]   mem_q [DEPTH];

   logic fifo_empty;
   logic push;
   logic pop;

   assign fifo_empty = (occ_q == '0);
   // Space is judged from registered occupancy; a same-cycle pop does not open a slot early.
   assign heard__RDY = nRST && (occ_q != FULL_OCC);
   assign push       = heard__ENA && heard__RDY;

   assign byte__ENA  = (state_q == SHIFT) && byte__RDY;
   assign byte_v     = (state_q == SHIFT) ? sr_q[7:0] : 8'h00;
   assign byte_last  = (state_q == SHIFT) && (idx_q == 2'd3);
   assign word_count = word_count_q;

   // Serializer next-state. A pop on the last byte reloads sr directly so words
   // stream back to back without an idle cycle.
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      idx_d        = idx_q;
      word_count_d = word_count_q;
      pop          = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               sr_d    = mem_q[rd_ptr_q];
               idx_d   = 2'd0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (byte__ENA) begin
               if (idx_q != 2'd3) begin
                  sr_d  = {8'h00, sr_q[31:8]};
                  idx_d = idx_q + 2'd1;
               end else begin
                  word_count_d = word_count_q + 16'd1;
                  if (!fifo_empty) begin
                     pop   = 1'b1;
                     sr_d  = mem_q[rd_ptr_q];
                     idx_d = 2'd0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      occ_d = occ_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + (AW+1)'(1);
         2'b01:   occ_d = occ_q - (AW+1)'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         idx_q        <= '0;
         word_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         idx_q        <= idx_d;
         word_count_q <= word_count_d;
         occ_q        <= occ_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Storage needs no reset: occupancy guards every read.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= heard_v;
   end

endmodule

// File: tb/tb_echo_heard_serializer.sv
// Bench for echo_heard_serializer: word-level reference model feeding a byte scoreboard,
// directed timing checks, randomized traffic, async reset and counter wrap.
module tb_echo_heard_serializer;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        heard__ENA;
   logic [31:0] heard_v;
   logic        heard__RDY;
   logic        byte__ENA;
   logic [7:0]  byte_v;
   logic        byte_last;
   logic        byte__RDY;
   logic [15:0] word_count;

   echo_heard_serializer #(.DEPTH(4)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .heard__ENA (heard__ENA),
      .heard_v    (heard_v),
      .heard__RDY (heard__RDY),
      .byte__ENA  (byte__ENA),
      .byte_v     (byte_v),
      .byte_last  (byte_last),
      .byte__RDY  (byte__RDY),
      .word_count (word_count)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [8:0]  exp_q[$];     // {last, byte}
   int          ena_cycles[$];
   logic [15:0] cnt_model = 16'd0;
   logic        cnt_pending = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every emitted byte is matched against the scoreboard; word_count is
   // checked one cycle after each word-completing byte.
   always @(negedge CLK) begin
      if (nRST) begin
         if (cnt_pending) begin
            check("word_count_after_word", 32'(word_count), 32'(cnt_model));
            cnt_pending = 1'b0;
         end
         if (byte__ENA) begin
            ena_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_byte", 32'(byte_v), 32'hFFFF_FFFF);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("byte_v", 32'(byte_v), 32'(e[7:0]));
               check("byte_last", 32'(byte_last), 32'(e[8]));
               if (e[8]) begin
                  cnt_model   = cnt_model + 16'd1;
                  cnt_pending = 1'b1;
               end
            end
         end
      end
   end

   // Reference model: a word becomes four bytes, LSB first, last flag on byte 3.
   task automatic model_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         logic [8:0] e;
         e = {(i == 3), w[8*i +: 8]};
         exp_q.push_back(e);
      end
   endtask

   // Called at posedge+1. Waits for space (opening byte__RDY so the wait can end).
   task automatic push_word(input logic [31:0] w);
      int t;
      t = 0;
      while (!heard__RDY && t < 200) begin
         byte__RDY = 1'b1;
         @(posedge CLK); #1;
         t++;
      end
      if (!heard__RDY) begin
         check("push_timeout", 32'(heard__RDY), 32'd1);
      end else begin
         heard__ENA = 1'b1;
         heard_v    = w;
         model_word(w);
         @(posedge CLK); #1;
         heard__ENA = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
         @(negedge CLK);
         t++;
      end
      check("drain_complete", 32'(exp_q.size()), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      @(posedge CLK); #1;
   endtask

   task automatic wait_byte();
      int t;
      t = 0;
      @(negedge CLK);
      while (!byte__ENA && t < 50) begin
         @(negedge CLK);
         t++;
      end
      check("byte_seen", 32'(byte__ENA), 32'd1);
   endtask

   initial begin
      int c0;
      logic [15:0] base;
      nRST       = 1'b0;
      heard__ENA = 1'b0;
      heard_v    = '0;
      byte__RDY  = 1'b1;

      // Reset state
      #1;
      check("rst_heard_rdy", 32'(heard__RDY), 32'd0);
      check("rst_byte_ena",  32'(byte__ENA),  32'd0);
      check("rst_byte_v",    32'(byte_v),     32'd0);
      check("rst_byte_last", 32'(byte_last),  32'd0);
      check("rst_word_count",32'(word_count), 32'd0);
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      #1;
      check("rdy_after_release", 32'(heard__RDY), 32'd1);
      @(posedge CLK); #1;

      // Single word: byte__ENA in cycles N+2..N+5
      ena_cycles.delete();
      c0 = cyc;
      push_word(32'hA1B2C3D4);
      wait_drain();
      check("single_nbytes", 32'(ena_cycles.size()), 32'd4);
      for (int i = 0; i < 4 && i < ena_cycles.size(); i++)
         check("single_cycle", 32'(ena_cycles[i]), 32'(c0 + 2 + i));
      check("single_count", 32'(word_count), 32'd1);

      // Back-to-back words: 8 gapless bytes
      ena_cycles.delete();
      base = word_count;
      push_word(32'h03020100);
      push_word(32'h07060504);
      wait_drain();
      check("b2b_nbytes", 32'(ena_cycles.size()), 32'd8);
      for (int i = 1; i < ena_cycles.size(); i++)
         check("b2b_no_gap", 32'(ena_cycles[i] - ena_cycles[i-1]), 32'd1);
      check("b2b_count", 32'(word_count - base), 32'd2);

      // Full FIFO: 1 word in sr + 4 buffered, then release
      byte__RDY = 1'b0;
      push_word(32'h11111111);
      push_word(32'h22222222);
      push_word(32'h33333333);
      push_word(32'h44444444);
      push_word(32'h55555555);
      @(negedge CLK);
      check("full_rdy_low", 32'(heard__RDY), 32'd0);
      @(posedge CLK); #1;
      byte__RDY = 1'b1;
      ena_cycles.delete();
      // Pop from full happens on the 4th byte; space shows the cycle after.
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check("full_rdy_seq", 32'(heard__RDY), 32'(k == 4));
      end
      wait_drain();
      check("full_nbytes", 32'(ena_cycles.size()), 32'd20);

      // Stall mid-word after byte EF
      base = word_count;
      push_word(32'hDEADBEEF);
      wait_byte();
      check("stall_first", 32'(byte_v), 32'hEF);
      @(posedge CLK); #1;
      byte__RDY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("stall_hold_v",   32'(byte_v),    32'hBE);
         check("stall_hold_ena", 32'(byte__ENA), 32'd0);
      end
      @(posedge CLK); #1;
      byte__RDY = 1'b1;
      wait_drain();
      check("stall_count", 32'(word_count - base), 32'd1);

      // Randomized traffic with random downstream backpressure
      for (int n = 0; n < 60; n++) begin
         byte__RDY = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) push_word($urandom());
         else begin @(posedge CLK); #1; end
      end
      byte__RDY = 1'b1;
      wait_drain();

      // Async reset while byte 1 of 0xCAFEF00D is presented
      push_word(32'hCAFEF00D);
      wait_byte();
      @(negedge CLK);
      check("arst_byte1", 32'(byte_v), 32'hF0);
      #2;
      nRST = 1'b0;
      exp_q.delete();
      cnt_pending = 1'b0;
      cnt_model   = 16'd0;
      #1;
      check("arst_byte_ena",  32'(byte__ENA),  32'd0);
      check("arst_byte_v",    32'(byte_v),     32'd0);
      check("arst_word_count",32'(word_count), 32'd0);
      check("arst_heard_rdy", 32'(heard__RDY), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      check("arst_rdy_release", 32'(heard__RDY), 32'd1);
      ena_cycles.delete();
      repeat (10) @(negedge CLK);
      check("arst_no_bytes", 32'(ena_cycles.size()), 32'd0);
      @(posedge CLK); #1;

      // Counter wrap: preload near the top instead of streaming 65536 words
      force dut.word_count_q = 16'hFFFE;
      #1;
      release dut.word_count_q;
      cnt_model = 16'hFFFE;
      @(negedge CLK);
      check("wrap_preload", 32'(word_count), 32'hFFFE);
      @(posedge CLK); #1;
      push_word(32'h12345678);
      wait_drain();
      check("wrap_ffff", 32'(word_count), 32'hFFFF);
      push_word(32'h9ABCDEF0);
      wait_drain();
      check("wrap_zero", 32'(word_count), 32'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
